sprite_line_ctrl: RTL and testbench
===================================

SPRITE_LINE_CTRL -- requirements
Module: sprite_line_ctrl

Interface
REQ-001 Parameter: none; line length is fixed at 256 pixels and sprite width at 8 pixels.
REQ-002 clk  in  1  system clock; all logic is on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 line_start  in  1  one-cycle pulse at the start of each scanline's blanking.
REQ-005 spr_valid  in  1  sprite descriptor is valid.
REQ-006 spr_ready  out  1  controller accepts the descriptor this cycle.
REQ-007 spr_x  in  8  sprite left pixel column.
REQ-008 spr_pat  in  32  four bitplanes; plane p is in bits [8p+7:8p]; pixel i uses bit 7-i; colour = {p3,p2,p1,p0}.
REQ-009 spr_end  in  1  pulse: no more sprites for this line.
REQ-010 linesel  out  1  line-buffer half selector for the write port.
REQ-011 lb_idx  out  8  line-buffer write-port address.
REQ-012 lb_wrdata  out  8  line-buffer write data.
REQ-013 lb_wren  out  1  line-buffer write enable.
REQ-014 lb_rddata  in  8  line-buffer write-port read data, valid one cycle after the address is presented.
REQ-015 busy  out  1  high in any state other than IDLE and DONE.
REQ-016 collision  out  1  sticky flag: an opaque pixel hit an already-opaque pixel on this line.
REQ-017 late  out  1  one-cycle pulse: line_start arrived while busy.

Function
REQ-018 States SHALL be IDLE, CLEAR, WAIT_SPR, READ, WRITE and DONE.
REQ-019 On line_start in any state, linesel SHALL invert, collision SHALL clear, the state SHALL go to CLEAR with clear counter 0, and all effects SHALL be visible on the next cycle.
REQ-020 If busy=1 in the cycle line_start is asserted, late SHALL pulse for exactly one cycle; any in-progress sprite is abandoned.
REQ-021 CLEAR SHALL write 8'h00 to lb_idx 0..255 on 256 consecutive cycles with lb_wren=1, then enter WAIT_SPR.
REQ-022 spr_ready SHALL be 1 only in WAIT_SPR; a transfer occurs when spr_valid=1 and spr_ready=1, which latches spr_x and spr_pat, sets pixel counter i=0 and enters READ.
REQ-023 In WAIT_SPR, spr_end=1 with no transfer SHALL enter DONE; if spr_end and a transfer coincide, the transfer wins and spr_end is ignored.
REQ-024 READ SHALL drive lb_idx = x+i (low 8 bits) with lb_wren=0, then enter WRITE.
REQ-025 WRITE SHALL drive the same lb_idx.
REQ-026 In WRITE, the pixel is drawn iff colour!=0 and x+i<=255 (9-bit sum; no wrap-around).
REQ-027 A drawn pixel with lb_rddata[4]=0 SHALL write {3'b000,1'b1,colour}.
REQ-028 A drawn pixel with lb_rddata[4]=1 SHALL NOT write and SHALL set collision, so the earlier sprite has priority.
REQ-029 After WRITE, if i<7 then i SHALL increment and the state SHALL return to READ; otherwise the state SHALL return to WAIT_SPR.
REQ-030 Each sprite SHALL take exactly 16 cycles from acceptance to the next possible spr_ready, regardless of transparency or clipping.
REQ-031 DONE SHALL hold with lb_wren=0 until line_start.
REQ-032 lb_wren SHALL be 0 in IDLE, WAIT_SPR, READ and DONE.

Reset
REQ-033 Reset SHALL force state=IDLE, linesel=0, lb_idx=0, lb_wrdata=0, lb_wren=0, spr_ready=0, busy=0, collision=0, late=0 and all counters to 0.
REQ-034 Reset SHALL take priority over line_start in the same cycle.
REQ-035 Reset mid-line SHALL abandon all work; the next line_start SHALL begin normally with no late pulse.

Structure
REQ-036 The state encoding and constants LINE_PIXELS=256, SPR_WIDTH=8 and OPAQUE_BIT=4 SHALL live in a shared video package.
REQ-037 A sub-module, spr_pixel_sel, SHALL be used: combinational extraction of colour i from spr_pat.
REQ-038 The block SHALL connect directly to the existing dual-port line buffer's write port (port 1).

Verification
REQ-039 Reset then line_start: linesel goes 0->1, and 256 writes of 00 occur at idx 0..255, then spr_ready=1 on cycle 258 after the pulse.
REQ-040 One sprite with x=10 and spr_pat=32'h000000FF: idx 10..17 are written with 8'h11; collision stays 0; exactly 16 cycles elapse.
REQ-041 Sprite A (x=20, plane0=FF) then sprite B (x=24, plane1=FF): idx 24..27 keep 8'h11, idx 28..31 get 8'h12, and collision=1.
REQ-042 Sprite x=252 with all pixels opaque: only idx 252..255 are written, with no writes to idx 0..3.
REQ-043 line_start during READ of the third sprite: late pulses once, linesel toggles, collision clears and CLEAR restarts at idx 0.
REQ-044 spr_end and spr_valid asserted together in WAIT_SPR: the sprite is accepted, and DONE is not entered until a later spr_end.

Source files
------------

// File: rtl/sprite_line_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sprite_line_ctrl_pkg
// Shared video definitions for the sprite line controller: line and sprite
// geometry, the position of the opaque marker in a line-buffer byte, the
// controller state encoding and a small helper deciding when the controller
// counts as busy.
// ---------------------------------------------------------------------------
package sprite_line_ctrl_pkg;

  localparam int LINE_PIXELS = 256;
  localparam int SPR_WIDTH   = 8;
  localparam int OPAQUE_BIT  = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    WAIT_SPR = 3'd2,
    READ     = 3'd3,
    WRITE    = 3'd4,
    DONE     = 3'd5
  } state_e;

  // IDLE and DONE are the only resting states; everything else is line work.
  function automatic logic is_busy(input state_e s);
    return !((s == IDLE) || (s == DONE));
  endfunction

endpackage

// File: rtl/sprite_line_ctrl_if.sv
// ---------------------------------------------------------------------------
// sprite_line_ctrl_if
// Bundles the sprite descriptor handshake and the line-buffer write port
// (port 1 of the dual-port line buffer).
//   spr_valid/spr_ready/spr_x/spr_pat/spr_end : sprite descriptor stream
//   lb_idx/lb_wrdata/lb_wren                  : line-buffer address/write
//   lb_rddata                                 : line-buffer read data, one
//                                               cycle after lb_idx
// The controller uses the slave modport; the sprite source together with
// the line buffer sits on the master side.
// ---------------------------------------------------------------------------
interface sprite_line_ctrl_if;
  import sprite_line_ctrl_pkg::*;

  logic        spr_valid;
  logic        spr_ready;
  logic [7:0]  spr_x;
  logic [31:0] spr_pat;
  logic        spr_end;
  logic [7:0]  lb_idx;
  logic [7:0]  lb_wrdata;
  logic        lb_wren;
  logic [7:0]  lb_rddata;

  modport slave (
    input  spr_valid, spr_x, spr_pat, spr_end, lb_rddata,
    output spr_ready, lb_idx, lb_wrdata, lb_wren
  );

  modport master (
    output spr_valid, spr_x, spr_pat, spr_end, lb_rddata,
    input  spr_ready, lb_idx, lb_wrdata, lb_wren
  );

endinterface

// File: rtl/sprite_line_ctrl_spr_pixel_sel.sv
// ---------------------------------------------------------------------------
// spr_pixel_sel
// Combinational extraction of one 4-bit colour from a sprite pattern.
//   pat    in  32  four bitplanes, plane p in bits [8p+7:8p]
//   pix    in   3  pixel number 0..7, pixel 0 is the leftmost
//   colour out  4  {plane3, plane2, plane1, plane0} bits of that pixel
// ---------------------------------------------------------------------------
module spr_pixel_sel
  import sprite_line_ctrl_pkg::*;
(
  input  logic [31:0] pat,
  input  logic [2:0]  pix,
  output logic [3:0]  colour
);

  // Pixel i lives at bit 7-i of each plane, which for a 3-bit index is ~i.
  logic [2:0] bit_sel;

  assign bit_sel = ~pix;

  always_comb begin
    colour = 4'h0;
    for (int p = 0; p < 4; p++) begin
      colour[p] = pat[{p[1:0], bit_sel}];
    end
  end

endmodule

// File: rtl/sprite_line_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_line_ctrl
// Per-scanline sprite compositor. On every line_start it flips the active
// line-buffer half, clears all 256 pixels, then accepts sprite descriptors
// and draws each 8-pixel sprite with a read-modify-write per pixel. Pixels
// already marked opaque keep their value (earlier sprite has priority) and
// raise the sticky collision flag.
//   clk, reset  : clock, synchronous active-high reset
//   line_start  : one-cycle pulse at the start of blanking
//   spr_if      : sprite handshake + line-buffer write port (slave modport)
//   linesel     : line-buffer half selector for the write port
//   busy        : high outside IDLE and DONE
//   collision   : sticky opaque-on-opaque flag for the current line
//   late        : one-cycle pulse when line_start arrived while busy
// ---------------------------------------------------------------------------
module sprite_line_ctrl
  import sprite_line_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     line_start,
  sprite_line_ctrl_if.slave        spr_if,
  output logic                     linesel,
  output logic                     busy,
  output logic                     collision,
  output logic                     late
);

  state_e      state_q, state_d;
  logic        linesel_q, linesel_d;
  logic        collision_q, collision_d;
  logic        late_q, late_d;
  logic        busy_q, busy_d;
  logic        spr_ready_q, spr_ready_d;
  logic [7:0]  lb_idx_q, lb_idx_d;
  logic [7:0]  clr_cnt_q, clr_cnt_d;
  logic [2:0]  pix_q, pix_d;
  logic [7:0]  x_q, x_d;
  logic [31:0] pat_q, pat_d;

  logic [3:0]  colour;
  logic [8:0]  pix_col;
  logic        in_range;
  logic        draw;
  logic        opaque;

  spr_pixel_sel u_pixel_sel (
    .pat    (pat_q),
    .pix    (pix_q),
    .colour (colour)
  );

  // Sprite column computed with a carry so pixels past column 255 are
  // clipped instead of wrapping to the left edge.
  assign pix_col  = {1'b0, x_q} + {6'b000000, pix_q};
  assign in_range = ~pix_col[8];
  assign draw     = (colour != 4'h0) && in_range;
  assign opaque   = spr_if.lb_rddata[OPAQUE_BIT];

  // Next-state logic. line_start is applied last so it overrides whatever
  // the current state was doing, including a sprite in flight.
  always_comb begin
    state_d     = state_q;
    linesel_d   = linesel_q;
    collision_d = collision_q;
    late_d      = 1'b0;
    lb_idx_d    = lb_idx_q;
    clr_cnt_d   = clr_cnt_q;
    pix_d       = pix_q;
    x_d         = x_q;
    pat_d       = pat_q;

    case (state_q)
      IDLE: begin
      end
      CLEAR: begin
        if (clr_cnt_q == 8'(LINE_PIXELS - 1)) begin
          state_d = WAIT_SPR;
        end else begin
          clr_cnt_d = clr_cnt_q + 8'd1;
          lb_idx_d  = clr_cnt_q + 8'd1;
        end
      end
      WAIT_SPR: begin
        if (spr_ready_q && spr_if.spr_valid) begin
          x_d      = spr_if.spr_x;
          pat_d    = spr_if.spr_pat;
          pix_d    = 3'd0;
          lb_idx_d = spr_if.spr_x;
          state_d  = READ;
        end else if (spr_if.spr_end) begin
          state_d = DONE;
        end
      end
      READ: begin
        state_d = WRITE;
      end
      WRITE: begin
        if (draw && opaque) begin
          collision_d = 1'b1;
        end
        // Transparent and clipped pixels still spend their READ/WRITE pair,
        // which keeps every sprite at a fixed 16-cycle cost.
        if (pix_q != 3'(SPR_WIDTH - 1)) begin
          pix_d    = pix_q + 3'd1;
          lb_idx_d = x_q + {5'b00000, pix_q + 3'd1};
          state_d  = READ;
        end else begin
          state_d = WAIT_SPR;
        end
      end
      DONE: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (line_start) begin
      linesel_d   = ~linesel_q;
      collision_d = 1'b0;
      late_d      = busy_q;
      state_d     = CLEAR;
      clr_cnt_d   = 8'd0;
      lb_idx_d    = 8'd0;
      pix_d       = 3'd0;
    end

    busy_d      = is_busy(state_d);
    spr_ready_d = (state_d == WAIT_SPR);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      linesel_q   <= 1'b0;
      collision_q <= 1'b0;
      late_q      <= 1'b0;
      busy_q      <= 1'b0;
      spr_ready_q <= 1'b0;
      lb_idx_q    <= 8'd0;
      clr_cnt_q   <= 8'd0;
      pix_q       <= 3'd0;
      x_q         <= 8'd0;
      pat_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      linesel_q   <= linesel_d;
      collision_q <= collision_d;
      late_q      <= late_d;
      busy_q      <= busy_d;
      spr_ready_q <= spr_ready_d;
      lb_idx_q    <= lb_idx_d;
      clr_cnt_q   <= clr_cnt_d;
      pix_q       <= pix_d;
      x_q         <= x_d;
      pat_q       <= pat_d;
    end
  end

  // The write decision in WRITE depends on read data that only arrives in
  // that same cycle, so the write strobe and data are decoded from the
  // registered state rather than registered themselves.
  always_comb begin
    spr_if.lb_wren   = 1'b0;
    spr_if.lb_wrdata = 8'h00;
    if (state_q == CLEAR) begin
      spr_if.lb_wren = 1'b1;
    end else if (state_q == WRITE) begin
      spr_if.lb_wren   = draw && !opaque;
      spr_if.lb_wrdata = {3'b000, 1'b1, colour};
    end
  end

  assign spr_if.spr_ready = spr_ready_q;
  assign spr_if.lb_idx    = lb_idx_q;
  assign linesel          = linesel_q;
  assign busy             = busy_q;
  assign collision        = collision_q;
  assign late             = late_q;

endmodule

// File: tb/tb_sprite_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sprite_line_ctrl
// Directed bench for sprite_line_ctrl with a behavioural dual-half line
// buffer on the write port. A table of single-sprite lines covers colour
// extraction, clipping and timing; hand-written sequences cover collision,
// late line_start, handshake/end coincidence and reset behaviour.
// ---------------------------------------------------------------------------
module tb_sprite_line_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic line_start;
  logic linesel;
  logic busy;
  logic collision;
  logic late;

  sprite_line_ctrl_if bus ();

  sprite_line_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .spr_if     (bus.slave),
    .linesel    (linesel),
    .busy       (busy),
    .collision  (collision),
    .late       (late)
  );

  always #5 clk = ~clk;

  // Line buffer write port: synchronous read, write on lb_wren.
  logic [7:0] mem [0:511];
  int         wr_count = 0;

  always @(posedge clk) begin
    bus.lb_rddata <= mem[{linesel, bus.lb_idx}];
    if (bus.lb_wren) begin
      mem[{linesel, bus.lb_idx}] <= bus.lb_wrdata;
      wr_count <= wr_count + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic exp_linesel = 1'b0;

  typedef struct {
    logic [7:0]  x;
    logic [31:0] pat;
    logic [7:0]  probe_idx;
    logic [7:0]  probe_exp;
    int          exp_writes;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ls, input logic v,
                               input logic [7:0] x, input logic [31:0] pat,
                               input logic e);
    line_start    = ls;
    bus.spr_valid = v;
    bus.spr_x     = x;
    bus.spr_pat   = pat;
    bus.spr_end   = e;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.spr_ready && n < 400) begin
      tick();
      n++;
    end
    if (!bus.spr_ready) begin
      checkOutput({name, "_ready_timeout"}, 32'(bus.spr_ready), 32'd1);
    end
  endtask

  // Pulse line_start, check the new-line side effects, wait for CLEAR end.
  task automatic start_line(input string name);
    applyStimulus(1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    exp_linesel = ~exp_linesel;
    checkOutput({name, "_linesel"}, 32'(linesel), 32'(exp_linesel));
    checkOutput({name, "_late"}, 32'(late), 32'd0);
    wait_ready(name);
  endtask

  // Hand over one descriptor and count the busy cycles until ready again.
  task automatic send_sprite(input string name, input logic [7:0] x,
                             input logic [31:0] pat);
    int cyc;
    applyStimulus(1'b0, 1'b1, x, pat, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    cyc = 0;
    while (!bus.spr_ready && cyc < 40) begin
      cyc++;
      tick();
    end
    checkOutput({name, "_cycles"}, 32'(cyc), 32'd16);
  endtask

  task automatic end_line(input string name);
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    checkOutput({name, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [7:0] lb_at(input logic [7:0] idx);
    return mem[{linesel, idx}];
  endfunction

  initial begin
    int base;
    int ok_clear;

    // Single-sprite lines: x, pattern, probed index, expected byte, writes.
    vecs[0]  = '{8'd10,  32'h0000_00FF, 8'd10,  8'h11, 8};
    vecs[1]  = '{8'd10,  32'h0000_00FF, 8'd17,  8'h11, 8};
    vecs[2]  = '{8'd10,  32'h0000_00FF, 8'd18,  8'h00, 8};
    vecs[3]  = '{8'd0,   32'h0000_0080, 8'd0,   8'h11, 1};
    vecs[4]  = '{8'd40,  32'h8000_0000, 8'd40,  8'h18, 1};
    vecs[5]  = '{8'd40,  32'h0102_0408, 8'd45,  8'h12, 4};
    vecs[6]  = '{8'd40,  32'h0102_0408, 8'd47,  8'h18, 4};
    vecs[7]  = '{8'd100, 32'hF0F0_F0F0, 8'd103, 8'h1F, 4};
    vecs[8]  = '{8'd252, 32'hFFFF_FFFF, 8'd255, 8'h1F, 4};
    vecs[9]  = '{8'd252, 32'hFFFF_FFFF, 8'd0,   8'h00, 4};
    vecs[10] = '{8'd200, 32'h0000_0000, 8'd200, 8'h00, 0};
    vecs[11] = '{8'd250, 32'h0000_FF00, 8'd255, 8'h12, 6};

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    repeat (3) tick();

    checkOutput("rst_linesel", 32'(linesel), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(bus.spr_ready), 32'd0);
    checkOutput("rst_wren", 32'(bus.lb_wren), 32'd0);
    checkOutput("rst_idx", 32'(bus.lb_idx), 32'd0);
    checkOutput("rst_wrdata", 32'(bus.lb_wrdata), 32'd0);
    checkOutput("rst_collision", 32'(collision), 32'd0);
    checkOutput("rst_late", 32'(late), 32'd0);

    // Reset wins over a coincident line_start.
    applyStimulus(1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
    tick();
    checkOutput("rstprio_linesel", 32'(linesel), 32'd0);
    checkOutput("rstprio_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    tick();

    // First line: full clear sequence and ready on cycle 258 after pulse.
    applyStimulus(1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    exp_linesel = 1'b1;
    checkOutput("clr_linesel", 32'(linesel), 32'd1);
    ok_clear = 0;
    for (int k = 0; k < 256; k++) begin
      if (bus.lb_wren === 1'b1 && bus.lb_idx === 8'(k) &&
          bus.lb_wrdata === 8'h00 && bus.spr_ready === 1'b0)
        ok_clear++;
      tick();
    end
    checkOutput("clr_writes", 32'(ok_clear), 32'd256);
    checkOutput("clr_ready_258", 32'(bus.spr_ready), 32'd1);
    checkOutput("clr_wren_off", 32'(bus.lb_wren), 32'd0);
    end_line("clr");

    // Table-driven single-sprite lines.
    for (int v = 0; v < 12; v++) begin
      start_line($sformatf("v%0d", v));
      base = wr_count;
      send_sprite($sformatf("v%0d", v), vecs[v].x, vecs[v].pat);
      end_line($sformatf("v%0d", v));
      checkOutput($sformatf("v%0d_probe", v), 32'(lb_at(vecs[v].probe_idx)),
                  32'(vecs[v].probe_exp));
      checkOutput($sformatf("v%0d_writes", v), 32'(wr_count - base),
                  32'(vecs[v].exp_writes));
      checkOutput($sformatf("v%0d_collision", v), 32'(collision), 32'd0);
    end

    // Overlapping sprites: earlier sprite keeps priority, collision sticks.
    start_line("ab");
    base = wr_count;
    send_sprite("a", 8'd20, 32'h0000_00FF);
    checkOutput("a_collision", 32'(collision), 32'd0);
    send_sprite("b", 8'd24, 32'h0000_FF00);
    checkOutput("ab_collision", 32'(collision), 32'd1);
    checkOutput("ab_idx24", 32'(lb_at(8'd24)), 32'h11);
    checkOutput("ab_idx27", 32'(lb_at(8'd27)), 32'h11);
    checkOutput("ab_idx28", 32'(lb_at(8'd28)), 32'h12);
    checkOutput("ab_idx31", 32'(lb_at(8'd31)), 32'h12);
    checkOutput("ab_writes", 32'(wr_count - base), 32'd12);

    // line_start during READ of a third sprite.
    applyStimulus(1'b0, 1'b1, 8'd60, 32'hFFFF_FFFF, 1'b0);
    tick();
    checkOutput("late_in_read_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    exp_linesel = ~exp_linesel;
    checkOutput("late_pulse", 32'(late), 32'd1);
    checkOutput("late_linesel", 32'(linesel), 32'(exp_linesel));
    checkOutput("late_collision", 32'(collision), 32'd0);
    checkOutput("late_idx0", 32'(bus.lb_idx), 32'd0);
    checkOutput("late_wren", 32'(bus.lb_wren), 32'd1);
    tick();
    checkOutput("late_one_cycle", 32'(late), 32'd0);
    checkOutput("late_idx1", 32'(bus.lb_idx), 32'd1);
    wait_ready("late");
    end_line("late");

    // spr_end coinciding with a transfer: transfer wins.
    start_line("coinc");
    applyStimulus(1'b0, 1'b1, 8'd5, 32'h0000_00FF, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    checkOutput("coinc_busy", 32'(busy), 32'd1);
    checkOutput("coinc_ready", 32'(bus.spr_ready), 32'd0);
    wait_ready("coinc");
    checkOutput("coinc_wait_busy", 32'(busy), 32'd1);
    checkOutput("coinc_idx5", 32'(lb_at(8'd5)), 32'h11);
    end_line("coinc");

    // Reset mid-sprite, then a clean line with no late pulse.
    start_line("midrst");
    applyStimulus(1'b0, 1'b1, 8'd30, 32'h0000_00FF, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_linesel", 32'(linesel), 32'd0);
    exp_linesel = 1'b0;
    tick();
    start_line("afterrst");
    checkOutput("afterrst_busy", 32'(busy), 32'd1);
    end_line("afterrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
